// File: rtl/soda_pkg.sv
// ---------------------------------------------------------------------------
// soda_pkg
// Shared definitions for the soda dispenser front end and datapath.
//   - MONEY_W        : width of every cent quantity (coin value, tot, counts)
//   - COIN_ID_W      : width of the raw coin code from the mechanism
//   - COIN_*         : coin codes; any code with bit 2 set is invalid
//   - VAL_*          : cent value of each valid coin
//   - state_t        : coin_acceptor FSM state encoding
//   - coin_valid()   : true for the four legal coin codes
//   - coin_value()   : cent value of a coin code (0 for invalid codes)
// ---------------------------------------------------------------------------
package soda_pkg;

  localparam int MONEY_W   = 8;
  localparam int COIN_ID_W = 3;

  localparam logic [COIN_ID_W-1:0] COIN_NICKEL  = 3'b000;
  localparam logic [COIN_ID_W-1:0] COIN_DIME    = 3'b001;
  localparam logic [COIN_ID_W-1:0] COIN_QUARTER = 3'b010;
  localparam logic [COIN_ID_W-1:0] COIN_DOLLAR  = 3'b011;

  localparam logic [MONEY_W-1:0] VAL_NICKEL  = 8'd5;
  localparam logic [MONEY_W-1:0] VAL_DIME    = 8'd10;
  localparam logic [MONEY_W-1:0] VAL_QUARTER = 8'd25;
  localparam logic [MONEY_W-1:0] VAL_DOLLAR  = 8'd100;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEB_ON   = 3'd1,
    DECIDE   = 3'd2,
    WAIT_REL = 3'd3,
    DEB_OFF  = 3'd4
  } state_t;

  function automatic logic coin_valid(input logic [COIN_ID_W-1:0] id);
    return (id == COIN_NICKEL) || (id == COIN_DIME) ||
           (id == COIN_QUARTER) || (id == COIN_DOLLAR);
  endfunction

  function automatic logic [MONEY_W-1:0] coin_value(input logic [COIN_ID_W-1:0] id);
    logic [MONEY_W-1:0] v;
    v = '0;
    case (id)
      COIN_NICKEL:  v = VAL_NICKEL;
      COIN_DIME:    v = VAL_DIME;
      COIN_QUARTER: v = VAL_QUARTER;
      COIN_DOLLAR:  v = VAL_DOLLAR;
      default:      v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// ---------------------------------------------------------------------------
// coin_acceptor_if
// Bundles the coin mechanism inputs, the controller lockout and the
// acceptor results.
//   master : drives coin_sense, coin_id, hold; observes the results
//   slave  : the coin_acceptor itself
// Signal semantics (no backpressure exists on this path):
//   c and reject are single-cycle strobes, never high together; the consumer
//   must take them the cycle they appear. a is valid from the cycle c is high
//   and holds until the next accepted coin. dbg_state mirrors the FSM state.
// ---------------------------------------------------------------------------
interface coin_acceptor_if;
  import soda_pkg::*;

  logic                 coin_sense;
  logic [COIN_ID_W-1:0] coin_id;
  logic                 hold;
  logic                 c;
  logic [MONEY_W-1:0]   a;
  logic                 reject;
  logic                 busy;
  logic [MONEY_W-1:0]   coin_cnt;
  state_t               dbg_state;

  modport master (
    output coin_sense, coin_id, hold,
    input  c, a, reject, busy, coin_cnt, dbg_state
  );

  modport slave (
    input  coin_sense, coin_id, hold,
    output c, a, reject, busy, coin_cnt, dbg_state
  );

endinterface

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for asynchronous level inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both stages
//   i_d   : asynchronous input (WIDTH bits)
//   o_q   : synchronized output, two clocks of latency
// Multi-bit use is only safe for data that is stable while it is consumed
// (coin_id is held steady while coin_sense is high).
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/coin_acceptor.sv
// ---------------------------------------------------------------------------
// coin_acceptor
// Front end of the soda dispenser: synchronizes the coin mechanism, debounces
// insertion and release, classifies the coin and issues either a one-cycle
// accept strobe (c, with cent value a) or a one-cycle reject strobe.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : coin_acceptor_if.slave
//             coin_sense, coin_id (raw, async), hold (synchronous lockout)
//             c, a, reject, busy, coin_cnt, dbg_state
// Parameters:
//   DEBOUNCE_CYCLES : synchronized cycles a level must persist (1..255)
//   SAT_MAX         : saturation value of coin_cnt
// ---------------------------------------------------------------------------
module coin_acceptor
  import soda_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SAT_MAX         = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  coin_acceptor_if.slave  bus
);

  localparam logic [7:0]         DEB_LIM = 8'(DEBOUNCE_CYCLES);
  localparam logic [MONEY_W-1:0] SAT_LIM = MONEY_W'(SAT_MAX);

  // Synchronized mechanism signals
  logic                 w_sense_s;
  logic [COIN_ID_W-1:0] w_id_s;

  // FSM and datapath state
  state_t               r_state;
  state_t               w_state_nx;
  logic [7:0]           r_deb_cnt;
  logic [7:0]           w_deb_cnt_nx;
  logic [COIN_ID_W-1:0] r_id;
  logic                 w_id_ld;
  logic                 w_accept;
  logic                 w_reject;
  logic                 r_c;
  logic                 r_reject;
  logic [MONEY_W-1:0]   r_a;
  logic [MONEY_W-1:0]   r_coin_cnt;

  sync_2ff #(.WIDTH(1)) u_sync_sense (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.coin_sense),
    .o_q   (w_sense_s)
  );

  sync_2ff #(.WIDTH(COIN_ID_W)) u_sync_id (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.coin_id),
    .o_q   (w_id_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_deb_cnt <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_deb_cnt <= w_deb_cnt_nx;
    end
  end

  // Next state, debounce counter and decision strobes.
  // The IDLE sample that leaves for DEB_ON counts as the first stable cycle,
  // so DECIDE is entered after DEBOUNCE_CYCLES further matching samples.
  // hold comes from the synchronous controller and is only looked at in DECIDE.
  always_comb begin
    w_state_nx   = r_state;
    w_deb_cnt_nx = r_deb_cnt;
    w_id_ld      = 1'b0;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    case (r_state)
      IDLE: begin
        w_deb_cnt_nx = '0;
        if (w_sense_s) begin
          w_state_nx   = DEB_ON;
          w_deb_cnt_nx = 8'd1;
        end
      end
      DEB_ON: begin
        if (!w_sense_s) begin
          w_state_nx   = IDLE;
          w_deb_cnt_nx = '0;
        end else if (r_deb_cnt == DEB_LIM) begin
          w_state_nx   = DECIDE;
          w_deb_cnt_nx = '0;
          w_id_ld      = 1'b1;
        end else begin
          w_deb_cnt_nx = r_deb_cnt + 8'd1;
        end
      end
      DECIDE: begin
        w_state_nx   = WAIT_REL;
        w_deb_cnt_nx = '0;
        if (coin_valid(r_id) && !bus.hold) begin
          w_accept = 1'b1;
        end else begin
          w_reject = 1'b1;
        end
      end
      WAIT_REL: begin
        w_deb_cnt_nx = '0;
        if (!w_sense_s) begin
          w_state_nx   = DEB_OFF;
          w_deb_cnt_nx = 8'd1;
        end
      end
      DEB_OFF: begin
        if (w_sense_s) begin
          // Release bounce: still the same coin, wait for a clean release.
          w_state_nx   = WAIT_REL;
          w_deb_cnt_nx = '0;
        end else if (r_deb_cnt == DEB_LIM) begin
          w_state_nx   = IDLE;
          w_deb_cnt_nx = '0;
        end else begin
          w_deb_cnt_nx = r_deb_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nx   = IDLE;
        w_deb_cnt_nx = '0;
      end
    endcase
  end

  // Coin id is captured once at the end of insertion debounce; later
  // changes on coin_id cannot affect the decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id <= '0;
    end else if (w_id_ld) begin
      r_id <= w_id_s;
    end
  end

  // Result registers: a and coin_cnt move on the same edge that raises c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c        <= 1'b0;
      r_reject   <= 1'b0;
      r_a        <= '0;
      r_coin_cnt <= '0;
    end else begin
      r_c      <= w_accept;
      r_reject <= w_reject;
      if (w_accept) begin
        r_a <= coin_value(r_id);
        if (r_coin_cnt < SAT_LIM) begin
          r_coin_cnt <= r_coin_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.c         = r_c;
  assign bus.reject    = r_reject;
  assign bus.a         = r_a;
  assign bus.coin_cnt  = r_coin_cnt;
  assign bus.busy      = (r_state != IDLE);
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_coin_acceptor.sv
// ---------------------------------------------------------------------------
// tb_coin_acceptor
// Directed bench for coin_acceptor with DEBOUNCE_CYCLES=4, SAT_MAX=255.
// Inputs change 1ns after a rising edge; outputs are read at that same point,
// so "tick(n)" lands just after the n-th following edge.
// ---------------------------------------------------------------------------
module tb_coin_acceptor;
  import soda_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  coin_acceptor_if bus ();

  coin_acceptor #(
    .DEBOUNCE_CYCLES (4),
    .SAT_MAX         (255)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  // Pulse monitor: totals plus protocol violation counters
  int c_total   = 0;
  int rej_total = 0;
  int both_err  = 0;
  int dbl_c     = 0;
  int dbl_r     = 0;
  int a_err     = 0;
  logic       prev_c = 1'b0;
  logic       prev_r = 1'b0;
  logic [7:0] prev_a = 8'd0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.c && bus.reject) both_err++;
      if (bus.c && prev_c) dbl_c++;
      if (bus.reject && prev_r) dbl_r++;
      if (bus.c) c_total++;
      if (bus.reject) rej_total++;
      if ((bus.a !== prev_a) && !bus.c) a_err++;
    end
    prev_c = bus.c;
    prev_r = bus.reject;
    prev_a = bus.a;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      $error("check %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int c0;
  int r0;

  initial begin
    bus.coin_sense = 1'b0;
    bus.coin_id    = COIN_DIME;
    bus.hold       = 1'b0;
    rst_n          = 1'b0;

    // ---- reset held 3 cycles with a coin already present ----
    bus.coin_sense = 1'b1;
    tick(3);
    check("rst_c",      bus.c, 0);
    check("rst_reject", bus.reject, 0);
    check("rst_busy",   bus.busy, 0);
    check("rst_a",      bus.a, 0);
    check("rst_cnt",    bus.coin_cnt, 0);
    check("rst_state",  bus.dbg_state, IDLE);
    c0 = c_total; r0 = rej_total;
    rst_n = 1'b1;
    tick(7);
    check("rst_rel_c_early", bus.c, 0);
    tick(1);
    check("rst_rel_c",   bus.c, 1);
    check("rst_rel_a",   bus.a, 10);
    check("rst_rel_cnt", bus.coin_cnt, 1);
    bus.coin_sense = 1'b0;
    tick(20);
    check("rst_rel_c_pulses", c_total - c0, 1);
    check("rst_rel_rejects",  rej_total - r0, 0);
    check("rst_rel_idle",     bus.busy, 0);

    rst_n = 1'b0;
    tick(2);
    check("rst2_cnt", bus.coin_cnt, 0);
    check("rst2_a",   bus.a, 0);
    rst_n = 1'b1;
    tick(2);

    // ---- clean quarter ----
    c0 = c_total; r0 = rej_total;
    bus.coin_id    = COIN_QUARTER;
    bus.coin_sense = 1'b1;
    tick(3);
    check("q_busy",  bus.busy, 1);
    check("q_state", bus.dbg_state, DEB_ON);
    tick(4);
    check("q_c_early", bus.c, 0);
    tick(1);
    check("q_c",   bus.c, 1);
    check("q_a",   bus.a, 25);
    check("q_cnt", bus.coin_cnt, 1);
    tick(1);
    check("q_c_after", bus.c, 0);
    tick(11);
    bus.coin_sense = 1'b0;
    tick(20);
    check("q_c_pulses", c_total - c0, 1);
    check("q_rejects",  rej_total - r0, 0);
    check("q_idle",     bus.dbg_state, IDLE);

    // ---- invalid code 101 ----
    c0 = c_total; r0 = rej_total;
    bus.coin_id    = 3'b101;
    bus.coin_sense = 1'b1;
    tick(7);
    check("inv_rej_early", bus.reject, 0);
    tick(1);
    check("inv_rej", bus.reject, 1);
    check("inv_c",   bus.c, 0);
    check("inv_a",   bus.a, 25);
    check("inv_cnt", bus.coin_cnt, 1);
    tick(12);
    bus.coin_sense = 1'b0;
    tick(20);
    check("inv_c_pulses", c_total - c0, 0);
    check("inv_rejects",  rej_total - r0, 1);

    // ---- 3-cycle glitch ----
    c0 = c_total; r0 = rej_total;
    bus.coin_id    = COIN_DIME;
    bus.coin_sense = 1'b1;
    tick(3);
    bus.coin_sense = 1'b0;
    tick(10);
    check("gl_c_pulses", c_total - c0, 0);
    check("gl_rejects",  rej_total - r0, 0);
    check("gl_idle",     bus.dbg_state, IDLE);

    // ---- dime with a 2-cycle release dip ----
    bus.coin_sense = 1'b1;
    tick(15);
    check("dime_a",     bus.a, 10);
    check("dime_cnt",   bus.coin_cnt, 2);
    check("dime_state", bus.dbg_state, WAIT_REL);
    bus.coin_sense = 1'b0;
    tick(2);
    bus.coin_sense = 1'b1;
    tick(10);
    check("dip_state", bus.dbg_state, WAIT_REL);
    bus.coin_sense = 1'b0;
    tick(20);
    check("dip_c_pulses", c_total - c0, 1);
    check("dip_rejects",  rej_total - r0, 0);
    check("dip_cnt",      bus.coin_cnt, 2);

    // ---- dollar under lockout ----
    c0 = c_total; r0 = rej_total;
    bus.coin_id    = COIN_DOLLAR;
    bus.hold       = 1'b1;
    bus.coin_sense = 1'b1;
    tick(15);
    check("lock_rejects",  rej_total - r0, 1);
    check("lock_c_pulses", c_total - c0, 0);
    check("lock_cnt",      bus.coin_cnt, 2);
    check("lock_a",        bus.a, 10);
    bus.coin_sense = 1'b0;
    tick(20);

    // ---- dollar, hold dropped during debounce (before DECIDE) ----
    c0 = c_total; r0 = rej_total;
    bus.coin_sense = 1'b1;
    tick(4);
    bus.hold = 1'b0;
    tick(11);
    check("dol_c_pulses", c_total - c0, 1);
    check("dol_rejects",  rej_total - r0, 0);
    check("dol_a",        bus.a, 100);
    check("dol_cnt",      bus.coin_cnt, 3);
    bus.coin_sense = 1'b0;
    tick(20);

    // ---- five nickels at minimum spacing (11 cycles) ----
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    c0 = c_total;
    bus.coin_id = COIN_NICKEL;
    for (int i = 0; i < 5; i++) begin
      bus.coin_sense = 1'b1;
      tick(5);
      bus.coin_sense = 1'b0;
      tick(2);
      check("b2b_c_early", bus.c, 0);
      tick(1);
      check("b2b_c", bus.c, 1);
      check("b2b_a", bus.a, 5);
      tick(3);
    end
    check("b2b_c_pulses", c_total - c0, 5);
    check("b2b_cnt",      bus.coin_cnt, 5);

    // ---- sixth nickel aborted by reset mid-debounce ----
    c0 = c_total;
    bus.coin_sense = 1'b1;
    tick(4);
    check("abort_state", bus.dbg_state, DEB_ON);
    rst_n = 1'b0;
    bus.coin_sense = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(20);
    check("abort_c_pulses", c_total - c0, 0);
    check("abort_cnt",      bus.coin_cnt, 0);
    check("abort_idle",     bus.dbg_state, IDLE);

    // ---- saturation ----
    c0 = c_total;
    for (int i = 0; i < 255; i++) begin
      bus.coin_sense = 1'b1;
      tick(5);
      bus.coin_sense = 1'b0;
      tick(6);
    end
    check("sat_c_pulses", c_total - c0, 255);
    check("sat_cnt",      bus.coin_cnt, 255);
    bus.coin_sense = 1'b1;
    tick(5);
    bus.coin_sense = 1'b0;
    tick(3);
    check("sat256_c",   bus.c, 1);
    check("sat256_cnt", bus.coin_cnt, 255);
    check("sat256_a",   bus.a, 5);
    tick(10);

    // ---- protocol invariants over the whole run ----
    check("mon_c_and_reject", both_err, 0);
    check("mon_double_c",     dbl_c, 0);
    check("mon_double_rej",   dbl_r, 0);
    check("mon_a_without_c",  a_err, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front-end stage of the soda dispenser. It conditions the raw coin-mechanism signals, debounces the insertion event and classifies the coin. It then delivers a single-cycle coin pulse `c` with an 8-bit cent value `a`, which feed the controller and the `tot` accumulator in the soda datapath. Coins that are invalid, or that arrive while the dispenser is locked out, are flagged for return and never reach the datapath.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized cycles a sense level must persist to be accepted (legal range 1..255)
SAT_MAX, 255, saturation value of coin_cnt

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  reset; one clock, asynchronous assert, active-low
coin_sense  input  1  raw asynchronous coin-present level from mechanism
coin_id  input  3  raw coin code, stable while coin_sense high
hold  input  1  lockout from controller (dispensing); coins are rejected while high
c  output  1  one-cycle pulse: valid coin accepted
a  output  8  cent value of last accepted coin, held until next accept
reject  output  1  one-cycle pulse: coin must be returned
busy  output  1  high whenever the FSM is not in IDLE
coin_cnt  output  8  count of accepted coins, saturating at SAT_MAX

Behaviour:
- Reset values: c=0, a=0, reject=0, busy=0, coin_cnt=0, FSM=IDLE, debounce counter=0, synchronizers=0.
- Assertion of rst_n at any point, including mid-debounce, aborts the operation. No pulse is produced.
- Synchronization:
  - coin_sense and coin_id each pass through a 2-flop synchronizer; sense_s and id_s denote the outputs.
  - All decisions use only the synchronized values.
- Coin codes: 000=nickel 5, 001=dime 10, 010=quarter 25, 011=dollar 100; 100..111 are invalid.
- FSM states:
  - IDLE: busy=0, counter=0. sense_s=1 → DEB_ON with counter=1.
  - DEB_ON:
    - sense_s=0 → IDLE (glitch discarded, no output).
    - Otherwise counter++.
    - When counter==DEBOUNCE_CYCLES, register id_s and go to DECIDE.
  - DECIDE (one cycle), evaluated on the registered id and the current hold:
    - Valid code and hold=0 → c=1 next cycle, a=value, coin_cnt+1 (saturating).
    - Invalid code or hold=1 → reject=1 next cycle; a unchanged; coin_cnt unchanged.
    - Then go to WAIT_REL.
  - WAIT_REL: counter=0. sense_s=0 → DEB_OFF with counter=1.
  - DEB_OFF:
    - sense_s=1 → WAIT_REL (release glitch, same coin, no second pulse).
    - Counter reaching DEBOUNCE_CYCLES → IDLE.
- Latency: for a clean rising edge first sampled at edge k, c/reject is high for exactly the cycle after edge k+DEBOUNCE_CYCLES+3 (2 sync + count + DECIDE).
- c and reject are mutually exclusive and never high for more than one cycle per insertion.
- a changes only in the same cycle c rises, so the datapath may load on c.
- hold is sampled only in DECIDE. A hold change during debounce has no effect before that point.
- coin_id changes after the DEB_ON sample are ignored.
- A new insertion cannot begin until release debounce completes. The minimum spacing between c pulses is 2·DEBOUNCE_CYCLES+3 cycles.
- coin_cnt at SAT_MAX stays at SAT_MAX; c still pulses.

Decomposition:
- Package soda_pkg holds:
  - coin code localparams (COIN_NICKEL..COIN_DOLLAR)
  - cent values (VAL_NICKEL=8'd5, VAL_DIME=8'd10, VAL_QUARTER=8'd25, VAL_DOLLAR=8'd100)
  - FSM state encoding (IDLE, DEB_ON, DECIDE, WAIT_REL, DEB_OFF)
  - the 8-bit money width constant shared with the datapath.
- One sub-module, sync_2ff (parameterized width, async active-low reset). It is instantiated for coin_sense (1 bit) and coin_id (3 bits).
- The value lookup is a function in soda_pkg.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with coin_sense=1 → all outputs 0. Release with coin_sense already high → exactly one normal accept follows, timed from the first post-reset edge.
- Clean quarter (DEBOUNCE_CYCLES=4): coin_id=010, coin_sense high 20 cycles then low 20 → c=1 for exactly one cycle 7 edges after first sampled high, a=25, coin_cnt=1, reject never high.
- Glitch rejection: 3-cycle coin_sense pulse, then a 2-cycle low dip during WAIT_REL of a subsequent dime insertion → first pulse produces nothing; dime gives one c with a=10, and the dip gives no second c.
- Invalid/lockout:
  - coin_id=101 → reject pulse, a keeps previous 25.
  - Dollar (011) with hold=1 at DECIDE → reject, coin_cnt unchanged.
  - Dollar with hold=0 → c, a=100.
- Back-to-back: five nickels at minimum legal spacing → five c pulses, a=5 each, coin_cnt=5. Mid-debounce rst_n pulse on a sixth → no c, coin_cnt=0.
- Saturation: preload via 255 accepted coins → coin_cnt=255. The 256th coin still pulses c and coin_cnt stays 255.
